// File: rtl/addr_path.sv
// Address datapath: PC, MAR and a single-outstanding memory read handshake feeding the MDR.
// Optional sticky PC wrap flag is built only when ADDR_PATH_PC_WRAP_EN is defined.
module addr_path #(
  parameter int                   AddrWidth    = 16,
  parameter int                   DataWidth    = 8,
  parameter logic [AddrWidth-1:0] RESET_VECTOR = 16'hFFFE,
  parameter logic [AddrWidth-1:0] IRQ_VECTOR   = 16'hFFF8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pc_rst_ni,
  input  logic                 pc_ld_ni,
  input  logic                 mar_rst_ni,
  input  logic                 mar_ld_ni,
  input  logic [2:0]           pc_src_i,
  input  logic [1:0]           addr_src_i,
  input  logic [AddrWidth-1:0] data_i,
  input  logic [AddrWidth-1:0] ea_i,
  input  logic [AddrWidth-1:0] sp_i,
  input  logic [7:0]           offset_i,
  input  logic                 mem_ack_i,
  input  logic [DataWidth-1:0] mem_data_i,
  output logic [AddrWidth-1:0] pc_o,
  output logic [AddrWidth-1:0] mar_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_req_o,
  output logic [DataWidth-1:0] mdr_o,
  output logic                 busy_o,
  output logic                 pc_wrap_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic [AddrWidth-1:0] PC_INC1   = {{(AddrWidth-1){1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] PC_INC2   = {{(AddrWidth-2){1'b0}}, 2'd2};
  localparam logic [AddrWidth-1:0] ADDR_ZERO = {AddrWidth{1'b0}};
  localparam logic [DataWidth-1:0] DATA_ZERO = {DataWidth{1'b0}};

  state_t                 state_r;
  state_t                 state_next_s;
  logic [AddrWidth-1:0]   pc_r;
  logic [AddrWidth-1:0]   pc_cand_s;
  logic [AddrWidth-1:0]   mar_r;
  logic [AddrWidth-1:0]   mar_sel_s;
  logic [DataWidth-1:0]   mdr_r;
  logic [AddrWidth-1:0]   offset_ext_s;
  logic                   mar_take_s;
  logic                   mdr_cap_s;

  assign offset_ext_s = {{(AddrWidth-8){offset_i[7]}}, offset_i};

  // PC candidate value selected by pc_src_i
  always_comb begin
    pc_cand_s = pc_r;
    case (pc_src_i)
      3'd0:    pc_cand_s = pc_r + PC_INC1;
      3'd1:    pc_cand_s = pc_r + PC_INC2;
      3'd2:    pc_cand_s = pc_r + offset_ext_s;
      3'd3:    pc_cand_s = data_i;
      3'd4:    pc_cand_s = ea_i;
      3'd5:    pc_cand_s = RESET_VECTOR;
      3'd6:    pc_cand_s = IRQ_VECTOR;
      default: pc_cand_s = pc_r;
    endcase
  end

  // MAR source select; source 0 sees the PC before this edge's update
  always_comb begin
    mar_sel_s = pc_r;
    case (addr_src_i)
      2'd0:    mar_sel_s = pc_r;
      2'd1:    mar_sel_s = data_i;
      2'd2:    mar_sel_s = ea_i;
      2'd3:    mar_sel_s = sp_i;
      default: mar_sel_s = pc_r;
    endcase
  end

  // Read FSM next state; a MAR reset suppresses the load, so it never starts a read
  always_comb begin
    state_next_s = state_r;
    mar_take_s   = 1'b0;
    mdr_cap_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mar_take_s = mar_rst_ni & ~mar_ld_ni;
        if (mar_take_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack_i) begin
          mdr_cap_s    = 1'b1;
          mar_take_s   = mar_rst_ni & ~mar_ld_ni;
          state_next_s = mar_take_s ? ST_REQ : ST_IDLE;
        end else begin
          mar_take_s   = 1'b0;
          state_next_s = ST_REQ;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Program counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_r <= RESET_VECTOR;
    end else if (!pc_rst_ni) begin
      pc_r <= RESET_VECTOR;
    end else if (!pc_ld_ni) begin
      pc_r <= pc_cand_s;
    end
  end

  // Memory address register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mar_r <= ADDR_ZERO;
    end else if (!mar_rst_ni) begin
      mar_r <= ADDR_ZERO;
    end else if (mar_take_s) begin
      mar_r <= mar_sel_s;
    end
  end

  // Memory data register, captured only when a read completes
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mdr_r <= DATA_ZERO;
    end else if (mdr_cap_s) begin
      mdr_r <= mem_data_i;
    end
  end

`ifdef ADDR_PATH_PC_WRAP_EN
  logic pc_wrap_r;
  logic wrap_evt_s;

  // Unsigned carry/borrow detection: an add that lands below the old PC carried,
  // a negative-offset add that lands above it borrowed
  always_comb begin
    wrap_evt_s = 1'b0;
    case (pc_src_i)
      3'd0, 3'd1: wrap_evt_s = (pc_cand_s < pc_r);
      3'd2:       wrap_evt_s = offset_i[7] ? (pc_cand_s > pc_r) : (pc_cand_s < pc_r);
      default:    wrap_evt_s = 1'b0;
    endcase
  end

  // Sticky wrap flag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_wrap_r <= 1'b0;
    end else if (!pc_rst_ni) begin
      pc_wrap_r <= 1'b0;
    end else if (!pc_ld_ni && wrap_evt_s) begin
      pc_wrap_r <= 1'b1;
    end
  end

  assign pc_wrap_o = pc_wrap_r;
`else
  assign pc_wrap_o = 1'b0;
`endif

  assign pc_o       = pc_r;
  assign mar_o      = mar_r;
  assign mem_addr_o = mar_r;
  assign mdr_o      = mdr_r;
  assign mem_req_o  = (state_r == ST_REQ);
  assign busy_o     = (state_r == ST_REQ);

endmodule

// File: tb/tb_addr_path.sv
// Directed and randomized bench for addr_path, checked against an arithmetic model.
module tb_addr_path;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        pc_rst_ni, pc_ld_ni, mar_rst_ni, mar_ld_ni;
  logic [2:0]  pc_src_i;
  logic [1:0]  addr_src_i;
  logic [15:0] data_i, ea_i, sp_i;
  logic [7:0]  offset_i;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic [15:0] pc_o, mar_o, mem_addr_o;
  logic        mem_req_o, busy_o, pc_wrap_o;
  logic [7:0]  mdr_o;

  int n_vec = 0;
  int n_err = 0;

  int m_pc, m_mar, m_mdr;
  bit m_busy, m_wrap;

  addr_path dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pc_rst_ni(pc_rst_ni), .pc_ld_ni(pc_ld_ni),
    .mar_rst_ni(mar_rst_ni), .mar_ld_ni(mar_ld_ni),
    .pc_src_i(pc_src_i), .addr_src_i(addr_src_i),
    .data_i(data_i), .ea_i(ea_i), .sp_i(sp_i), .offset_i(offset_i),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .pc_o(pc_o), .mar_o(mar_o), .mem_addr_o(mem_addr_o),
    .mem_req_o(mem_req_o), .mdr_o(mdr_o), .busy_o(busy_o),
    .pc_wrap_o(pc_wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    pc_rst_ni = 1'b1; pc_ld_ni = 1'b1; mar_rst_ni = 1'b1; mar_ld_ni = 1'b1;
    pc_src_i = 3'd7; addr_src_i = 2'd0; data_i = 16'h0000; ea_i = 16'h0000;
    sp_i = 16'h0000; offset_i = 8'h00; mem_ack_i = 1'b0; mem_data_i = 8'h00;
  endtask

  task automatic model_reset();
    m_pc = 32'hFFFE; m_mar = 0; m_mdr = 0; m_busy = 1'b0; m_wrap = 1'b0;
  endtask

  // Reference behaviour for one rising edge, using the inputs as they stand
  task automatic model_edge();
    int  s;
    int  npc;
    int  src;
    bit  take;
    npc = m_pc;
    if (!pc_rst_ni) begin
      npc = 32'hFFFE;
      m_wrap = 1'b0;
    end else if (!pc_ld_ni) begin
      case (pc_src_i)
        3'd0, 3'd1, 3'd2: begin
          if (pc_src_i == 3'd0)      s = m_pc + 1;
          else if (pc_src_i == 3'd1) s = m_pc + 2;
          else                       s = m_pc + int'($signed(offset_i));
          if (s > 65535 || s < 0) m_wrap = 1'b1;
          npc = (s + 65536) % 65536;
        end
        3'd3: npc = int'(data_i);
        3'd4: npc = int'(ea_i);
        3'd5: npc = 32'hFFFE;
        3'd6: npc = 32'hFFF8;
        default: npc = m_pc;
      endcase
    end
    case (addr_src_i)
      2'd0: src = m_pc;
      2'd1: src = int'(data_i);
      2'd2: src = int'(ea_i);
      default: src = int'(sp_i);
    endcase
    take = !mar_ld_ni && mar_rst_ni && (!m_busy || mem_ack_i);
    if (!mar_rst_ni) m_mar = 0;
    else if (take)   m_mar = src;
    if (m_busy && mem_ack_i) m_mdr = int'(mem_data_i);
    if (!m_busy || mem_ack_i) m_busy = take;
    m_pc = npc;
  endtask

  task automatic check_all(input string where);
    bit exp_wrap;
`ifdef ADDR_PATH_PC_WRAP_EN
    exp_wrap = m_wrap;
`else
    exp_wrap = 1'b0;
`endif
    chk({where, ".pc"},   32'(pc_o),       32'(m_pc));
    chk({where, ".mar"},  32'(mar_o),      32'(m_mar));
    chk({where, ".addr"}, 32'(mem_addr_o), 32'(m_mar));
    chk({where, ".req"},  32'(mem_req_o),  32'(m_busy));
    chk({where, ".busy"}, 32'(busy_o),     32'(m_busy));
    chk({where, ".mdr"},  32'(mdr_o),      32'(m_mdr));
    chk({where, ".wrap"}, 32'(pc_wrap_o),  32'(exp_wrap));
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later
  task automatic step(input string where);
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(where);
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    check_all("reset");

    // Dirty the state, then apply reset mid-cycle and look before the next edge
    pc_ld_ni = 1'b0; pc_src_i = 3'd3; data_i = 16'h1234;
    mar_ld_ni = 1'b0; addr_src_i = 2'd1;
    step("dirty");
    idle_inputs();
    #3 reset_i = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.pc_const", 32'(pc_o), 32'h0000FFFE);
    chk("async_rst.req_const", 32'(mem_req_o), 32'h0);
    #1 reset_i = 1'b0;

    // Increment through the top of the address space, then branch back
    pc_ld_ni = 1'b0; pc_src_i = 3'd0;
    step("inc1");
    chk("inc1.pc_const", 32'(pc_o), 32'h0000FFFF);
    step("inc2");
    chk("inc2.pc_const", 32'(pc_o), 32'h00000000);
    pc_src_i = 3'd2; offset_i = 8'hF0;
    step("branch");
    chk("branch.pc_const", 32'(pc_o), 32'h0000FFF0);

    // Load PC, then PC+1 with MAR<-old PC on the same edge, then complete the read
    pc_src_i = 3'd3; data_i = 16'h1234;
    step("pc_abs");
    pc_src_i = 3'd0; mar_ld_ni = 1'b0; addr_src_i = 2'd0;
    step("mar_pc");
    chk("mar_pc.mar_const", 32'(mar_o), 32'h00001234);
    chk("mar_pc.pc_const",  32'(pc_o),  32'h00001235);
    idle_inputs();
    mem_ack_i = 1'b1; mem_data_i = 8'hA5;
    step("ack1");
    chk("ack1.mdr_const", 32'(mdr_o), 32'h000000A5);

    // Ack while idle must not touch MDR
    mem_data_i = 8'h3C;
    step("idle_ack");

    // Start a read, then try to reload MAR without an ack
    idle_inputs();
    mar_ld_ni = 1'b0; addr_src_i = 2'd1; data_i = 16'h3000;
    step("req2");
    data_i = 16'h4000;
    step("ignored_ld");
    chk("ignored_ld.mar_const", 32'(mar_o), 32'h00003000);

    // Back-to-back: ack and load on the same edge
    addr_src_i = 2'd2; ea_i = 16'h2000; mem_ack_i = 1'b1; mem_data_i = 8'h5A;
    step("b2b");
    chk("b2b.mar_const", 32'(mar_o), 32'h00002000);
    chk("b2b.req_const", 32'(mem_req_o), 32'h1);

    // MAR reset while a read is outstanding keeps the request alive at 0
    idle_inputs();
    mar_rst_ni = 1'b0;
    step("mar_rst_req");
    idle_inputs();
    mem_ack_i = 1'b1; mem_data_i = 8'h77;
    step("ack3");

    // PC reset overrides a simultaneous load and clears the wrap flag
    idle_inputs();
    pc_rst_ni = 1'b0; pc_ld_ni = 1'b0; pc_src_i = 3'd3; data_i = 16'h5555;
    step("pc_rst");
    chk("pc_rst.pc_const", 32'(pc_o), 32'h0000FFFE);
    chk("pc_rst.wrap_const", 32'(pc_wrap_o), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pc_rst_ni  = ($urandom_range(0, 15) != 0);
      pc_ld_ni   = $urandom_range(0, 1) == 1;
      mar_rst_ni = ($urandom_range(0, 15) != 0);
      mar_ld_ni  = $urandom_range(0, 1) == 1;
      pc_src_i   = 3'($urandom_range(0, 7));
      addr_src_i = 2'($urandom_range(0, 3));
      data_i     = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      ea_i       = 16'($urandom);
      sp_i       = 16'($urandom);
      offset_i   = 8'($urandom);
      mem_ack_i  = ($urandom_range(0, 4) < 2);
      mem_data_i = 8'($urandom);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
